// File: rtl/deserializer_stream_pkg.sv
// Shared sizing helpers and output-register state type for deserializer_stream.
package deserializer_stream_pkg;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_t;

  function automatic int calc_beats(input int in_w, input int out_w);
    return out_w / in_w;
  endfunction

  function automatic int calc_cnt_width(input int beats);
    int w;
    w = $clog2(beats);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/deserializer_stream_if.sv
// Valid/ready bundle for deserializer_stream; last/beat-count signals exist only
// with DESERIALIZER_STREAM_LAST_EN.
interface deserializer_stream_if #(
  parameter int in_width  = 1,
  parameter int out_width = 8
) ();
  import deserializer_stream_pkg::*;

  localparam int BEATS = calc_beats(in_width, out_width);

  logic                 in_valid;
  logic                 in_ready;
  logic [in_width-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [out_width-1:0] out_data;
`ifdef DESERIALIZER_STREAM_LAST_EN
  logic                 in_last;
  logic                 out_last;
  logic [$clog2(BEATS):0] out_beats;

  modport master (output in_valid, in_data, in_last, out_ready,
                  input  in_ready, out_valid, out_data, out_last, out_beats);
  modport slave  (input  in_valid, in_data, in_last, out_ready,
                  output in_ready, out_valid, out_data, out_last, out_beats);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/deserializer_stream_acc.sv
// Beat accumulator: slices incoming beats into a word and flags the completing beat.
// Early completion via in_last exists only with DESERIALIZER_STREAM_LAST_EN.
module deserializer_stream_acc
  import deserializer_stream_pkg::*;
#(
  parameter int in_width  = 1,
  parameter int out_width = 8,
  parameter int msb_first = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [in_width-1:0]  i_data,
`ifdef DESERIALIZER_STREAM_LAST_EN
  input  logic                 i_valid,
  input  logic                 i_last,
  output logic [$clog2(calc_beats(in_width, out_width)):0] o_beats,
`endif
  output logic                 o_completing,
  output logic [out_width-1:0] o_word
);
  localparam int BEATS = calc_beats(in_width, out_width);
  localparam int CW    = calc_cnt_width(BEATS);
  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  logic [CW-1:0]        r_cnt;
  logic [out_width-1:0] r_acc;
  logic [CW-1:0]        w_slice;
  logic [out_width-1:0] w_word;

  assign w_slice = (msb_first != 0) ? (LAST_IDX - r_cnt) : r_cnt;

  // Word as it would look with the current beat merged in; loaded on completion.
  always_comb begin
    w_word = r_acc;
    w_word[int'(w_slice) * in_width +: in_width] = i_data;
  end

`ifdef DESERIALIZER_STREAM_LAST_EN
  localparam int BW = $clog2(BEATS) + 1;
  assign o_completing = (r_cnt == LAST_IDX) || (i_valid && i_last);
  assign o_beats      = BW'(r_cnt) + BW'(1);
`else
  assign o_completing = (r_cnt == LAST_IDX);
`endif
  assign o_word = w_word;

  // Clearing on completion keeps unfilled slices of a short word at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_push) begin
      if (o_completing) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
        r_acc <= w_word;
      end
    end
  end
endmodule

// File: rtl/deserializer_stream.sv
// Stream deserializer: packs out_width/in_width beats into a registered, backpressured word.
// Optional last/flush support with DESERIALIZER_STREAM_LAST_EN.
module deserializer_stream
  import deserializer_stream_pkg::*;
#(
  parameter int in_width  = 1,
  parameter int out_width = 8,
  parameter int msb_first = 0
) (
  input logic                  clk,
  input logic                  rst,
  deserializer_stream_if.slave bus
);
  localparam int BEATS = calc_beats(in_width, out_width);

  if ((out_width % in_width) != 0 || out_width < 2 * in_width) begin : g_cfg_err
    $error("deserializer_stream: out_width must be a multiple of in_width and >= 2*in_width");
  end

  out_state_t           r_state;
  logic [out_width-1:0] r_data;
  logic [out_width-1:0] w_word;
  logic                 w_completing;
  logic                 w_in_ready;
  logic                 w_beat_xfer;
  logic                 w_load;

  // Non-final beats never stall; only the completing beat waits on a free output slot.
  assign w_in_ready  = !rst && (r_state == EMPTY || bus.out_ready || !w_completing);
  assign w_beat_xfer = bus.in_valid && w_in_ready;
  assign w_load      = w_beat_xfer && w_completing;

`ifdef DESERIALIZER_STREAM_LAST_EN
  localparam int BW = $clog2(BEATS) + 1;
  logic          r_last;
  logic [BW-1:0] r_beats;
  logic [BW-1:0] w_beats;
`endif

  deserializer_stream_acc #(
    .in_width  (in_width),
    .out_width (out_width),
    .msb_first (msb_first)
  ) u_acc (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_beat_xfer),
    .i_data       (bus.in_data),
`ifdef DESERIALIZER_STREAM_LAST_EN
    .i_valid      (bus.in_valid),
    .i_last       (bus.in_last),
    .o_beats      (w_beats),
`endif
    .o_completing (w_completing),
    .o_word       (w_word)
  );

  // A load in FULL implies out_ready, so the old word is consumed that same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_data  <= '0;
`ifdef DESERIALIZER_STREAM_LAST_EN
      r_last  <= 1'b0;
      r_beats <= '0;
`endif
    end else begin
      case (r_state)
        EMPTY:   if (w_load) r_state <= FULL;
        FULL:    if (bus.out_ready && !w_load) r_state <= EMPTY;
        default: r_state <= EMPTY;
      endcase
      if (w_load) begin
        r_data  <= w_word;
`ifdef DESERIALIZER_STREAM_LAST_EN
        r_last  <= bus.in_valid && bus.in_last;
        r_beats <= w_beats;
`endif
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == FULL);
  assign bus.out_data  = r_data;
`ifdef DESERIALIZER_STREAM_LAST_EN
  assign bus.out_last  = r_last;
  assign bus.out_beats = r_beats;
`endif
endmodule

// File: tb/tb_deserializer_stream.sv
// Bench for deserializer_stream: 1->8 LSB-first and 4->16 MSB-first instances against a queue model.
module tb_deserializer_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  deserializer_stream_if #(.in_width(1), .out_width(8))  b0 ();
  deserializer_stream_if #(.in_width(4), .out_width(16)) b1 ();

  deserializer_stream #(.in_width(1), .out_width(8), .msb_first(0)) u0 (
    .clk(clk), .rst(rst), .bus(b0));
  deserializer_stream #(.in_width(4), .out_width(16), .msb_first(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: beats collected as a list, words built by arithmetic packing.
  int                bcnt [2] = '{8, 4};
  int                bw   [2] = '{1, 4};
  bit                mf   [2] = '{1'b0, 1'b1};
  longint unsigned   bv   [2][16];
  int                bn   [2] = '{0, 0};
  bit                hv   [2] = '{1'b0, 1'b0};
  longint unsigned   hd   [2] = '{0, 0};
  bit                hl   [2] = '{1'b0, 1'b0};
  int                hb   [2] = '{0, 0};
  longint unsigned   got0 [$];
  longint unsigned   got1 [$];

  task automatic step(input int id, input bit ivld, input bit ilast, input bit irdy,
                      input bit ovld, input bit ordy, input longint unsigned idata,
                      input longint unsigned odata, input bit olast, input int obeats);
    bit compl;
    bit exp_rdy;
    longint unsigned w;
    int pos;
    compl   = (bn[id] == bcnt[id] - 1) || (ivld && ilast);
    exp_rdy = !rst && (!hv[id] || ordy || !compl);
    chk($sformatf("in_ready[%0d]", id), irdy, exp_rdy);
    chk($sformatf("out_valid[%0d]", id), ovld, hv[id]);
    if (hv[id]) begin
      chk($sformatf("out_data[%0d]", id), odata, hd[id]);
`ifdef DESERIALIZER_STREAM_LAST_EN
      chk($sformatf("out_last[%0d]", id), olast, hl[id]);
      chk($sformatf("out_beats[%0d]", id), obeats, hb[id]);
`endif
    end
    if (rst) begin
      bn[id] = 0; hv[id] = 0; hd[id] = 0; hl[id] = 0; hb[id] = 0;
      return;
    end
    if (hv[id] && ordy) begin
      if (id == 0) got0.push_back(hd[id]);
      else         got1.push_back(hd[id]);
      hv[id] = 0;
    end
    if (ivld && exp_rdy) begin
      bv[id][bn[id]] = idata;
      bn[id]++;
      if (compl) begin
        w = 0;
        for (int k = 0; k < bn[id]; k++) begin
          pos = mf[id] ? (bcnt[id] - 1 - k) : k;
          w   = w | (bv[id][k] << (pos * bw[id]));
        end
        hv[id] = 1; hd[id] = w; hl[id] = ilast; hb[id] = bn[id]; bn[id] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
`ifdef DESERIALIZER_STREAM_LAST_EN
    step(0, b0.in_valid, b0.in_last, b0.in_ready, b0.out_valid, b0.out_ready,
         64'(b0.in_data), 64'(b0.out_data), b0.out_last, int'(b0.out_beats));
    step(1, b1.in_valid, b1.in_last, b1.in_ready, b1.out_valid, b1.out_ready,
         64'(b1.in_data), 64'(b1.out_data), b1.out_last, int'(b1.out_beats));
`else
    step(0, b0.in_valid, 1'b0, b0.in_ready, b0.out_valid, b0.out_ready,
         64'(b0.in_data), 64'(b0.out_data), 1'b0, 0);
    step(1, b1.in_valid, 1'b0, b1.in_ready, b1.out_valid, b1.out_ready,
         64'(b1.in_data), 64'(b1.out_data), 1'b0, 0);
`endif
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called and returns at posedge+1; holds the beat until accepted (bounded).
  task automatic beat0(input logic d, input bit l);
    int t = 0;
    b0.in_valid = 1'b1;
    b0.in_data  = d;
`ifdef DESERIALIZER_STREAM_LAST_EN
    b0.in_last  = l;
`endif
    do begin @(negedge clk); t++; end while (!b0.in_ready && t < 20);
    chk("beat0_accept", b0.in_ready, 1);
    @(posedge clk); #1;
    b0.in_valid = 1'b0;
`ifdef DESERIALIZER_STREAM_LAST_EN
    b0.in_last  = 1'b0;
`endif
  endtask

  task automatic beat1(input logic [3:0] d);
    int t = 0;
    b1.in_valid = 1'b1;
    b1.in_data  = d;
    do begin @(negedge clk); t++; end while (!b1.in_ready && t < 20);
    chk("beat1_accept", b1.in_ready, 1);
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pat;
    logic [15:0] nib;
    longint      t0, t1;
    longint unsigned e0 [$];
    longint unsigned e1 [$];

    b0.in_valid = 0; b0.in_data = '0; b0.out_ready = 0;
    b1.in_valid = 0; b1.in_data = '0; b1.out_ready = 0;
`ifdef DESERIALIZER_STREAM_LAST_EN
    b0.in_last = 0; b1.in_last = 0;
`endif
    rst = 1'b1;
    tick(2);
    @(negedge clk);
    chk("rst_in_ready", b0.in_ready, 0);
    chk("rst_out_valid", b0.out_valid, 0);
    chk("rst_out_data", b0.out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1->8 LSB-first: 1,0,1,1,0,0,1,0 -> 8'h4D for one cycle
    b0.out_ready = 1'b1;
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) beat0(pat[i], 1'b0);
    @(negedge clk);
    chk("t1_valid", b0.out_valid, 1);
    chk("t1_data", b0.out_data, 8'h4D);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_valid_one_cycle", b0.out_valid, 0);
    @(posedge clk); #1;

    // 4->16 MSB-first: A,B,C,D then 1..8 back-to-back
    b1.out_ready = 1'b1;
    t0 = $time;
    nib = 16'hABCD;
    for (int i = 3; i >= 0; i--) beat1(nib[i*4 +: 4]);
    for (int i = 1; i <= 8; i++) beat1(4'(i));
    t1 = $time;
    chk("t2_no_bubbles", longint'((t1 - t0) / 10), 12);
    @(negedge clk);
    chk("t2_last_word", b1.out_data, 16'h5678);
    @(posedge clk); #1;

    // Backpressure: 16 beats with out_ready low (A5 then 3C)
    b0.out_ready = 1'b0;
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) beat0(pat[i], 1'b0);
    pat = 8'h3C;
    for (int i = 0; i < 7; i++) beat0(pat[i], 1'b0);
    b0.in_valid = 1'b1;
    b0.in_data  = pat[7];
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall_ready", b0.in_ready, 0);
      chk("bp_hold_valid", b0.out_valid, 1);
      chk("bp_hold_data", b0.out_data, 8'hA5);
      @(posedge clk); #1;
    end
    b0.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", b0.in_ready, 1);
    @(posedge clk); #1;
    b0.in_valid  = 1'b0;
    b0.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", b0.out_valid, 1);
    chk("bp_second_data", b0.out_data, 8'h3C);
    @(posedge clk); #1;
    b0.out_ready = 1'b1;
    tick(1);

    // Reset after 5 beats discards the partial word
    for (int i = 0; i < 5; i++) beat0(1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", b0.in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_out_valid", b0.out_valid, 0);
    chk("mid_rst_out_data", b0.out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pat = 8'h0A;
    b0.in_valid = 1'b1;
    b0.in_data  = pat[0];
    @(negedge clk);
    chk("post_rst_ready", b0.in_ready, 1);
    @(posedge clk); #1;
    b0.in_valid = 1'b0;
    for (int i = 1; i < 8; i++) beat0(pat[i], 1'b0);
    @(negedge clk);
    chk("post_rst_valid", b0.out_valid, 1);
    chk("post_rst_data", b0.out_data, 8'h0A);
    @(posedge clk); #1;

`ifdef DESERIALIZER_STREAM_LAST_EN
    beat0(1'b1, 1'b0);
    beat0(1'b1, 1'b0);
    beat0(1'b1, 1'b1);
    @(negedge clk);
    chk("last_short_data", b0.out_data, 8'h07);
    chk("last_short_last", b0.out_last, 1);
    chk("last_short_beats", b0.out_beats, 3);
    @(posedge clk); #1;
    pat = 8'h81;
    for (int i = 0; i < 8; i++) beat0(pat[i], 1'b0);
    @(negedge clk);
    chk("last_full_data", b0.out_data, 8'h81);
    chk("last_full_last", b0.out_last, 0);
    chk("last_full_beats", b0.out_beats, 8);
    @(posedge clk); #1;
`endif

    tick(3);
    e0.push_back(64'h4D); e0.push_back(64'hA5); e0.push_back(64'h3C); e0.push_back(64'h0A);
`ifdef DESERIALIZER_STREAM_LAST_EN
    e0.push_back(64'h07); e0.push_back(64'h81);
`endif
    e1.push_back(64'hABCD); e1.push_back(64'h1234); e1.push_back(64'h5678);
    chk("words0_count", got0.size(), e0.size());
    for (int i = 0; i < e0.size() && i < got0.size(); i++)
      chk($sformatf("words0[%0d]", i), got0[i], e0[i]);
    chk("words1_count", got1.size(), e1.size());
    for (int i = 0; i < e1.size() && i < got1.size(); i++)
      chk($sformatf("words1[%0d]", i), got1[i], e1[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/deserializer_stream.md
# deserializer_stream

Parametrised serial-to-parallel converter with flow control on both sides. Accepts `in_width`-bit beats over a valid/ready input and packs `out_width / in_width` consecutive beats into one word. Each word is presented on a registered valid/ready output that tolerates downstream backpressure without losing data or throughput. Sits between narrow link or PHY-side receivers and word-wide datapaths; it is the generalised replacement for the fixed 1-to-8 converter.

## Interface
- `in_width`, 1: bits per input beat; must be ≥1.
- `out_width`, 8: bits per output word; must be an integer multiple of `in_width`, ≥ 2·`in_width`.
- `msb_first`, 0: 0 = first beat lands in the least-significant slice; 1 = first beat lands in the most-significant slice.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: input beat present.
- `in_ready` output 1: block can accept a beat this cycle.
- `in_data` input `in_width`: beat payload.
- `out_valid` output 1: `out_data` holds a complete word.
- `out_ready` input 1: downstream accepts the word this cycle.
- `out_data` output `out_width`: assembled word.
- `in_last` input 1, `out_last` output 1, `out_beats` output `$clog2(BEATS)+1`: present only with `DESERIALIZER_STREAM_LAST_EN`.

## Operation
- `BEATS = out_width / in_width`; beat counter width = max(1, `$clog2(BEATS)`).
- Beat transfer = `in_valid && in_ready`; word transfer = `out_valid && out_ready`.
- Beat k of a word (k = 0..BEATS-1) is written to slice `[k*in_width +: in_width]` when `msb_first`=0, and to slice `[(BEATS-1-k)*in_width +: in_width]` when `msb_first`=1.
- Two storage elements: the accumulator (shift/slice register plus counter) and the output register (`out_data`, `out_valid`).
- Output register states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY→FULL: the completing beat is transferred.
  - FULL→EMPTY: a word transfer occurs with no completing beat in the same cycle.
  - FULL→FULL: a word transfer and a completing beat occur in the same cycle; the new word is loaded.
- `in_ready = !rst && (!out_valid || out_ready || !completing)`, where `completing` = counter == BEATS-1. Non-final beats are always accepted, even while the output is stalled.
- The counter wraps BEATS-1→0 on the completing beat. With `in_valid` low the counter holds, so idle gaps between beats are allowed.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- Reset: counter=0, accumulator=0, `out_valid`=0, `out_data`=0, `in_ready`=0 while `rst` is high. A partial word in progress is discarded, as is any held output word.

## Timing
- Latency: completing beat transferred in cycle N → `out_valid`=1 and word visible in cycle N+1.
- Throughput: with `out_ready` held high, one word per BEATS input cycles and no bubbles.
- `in_ready` is combinational from `out_valid`, `out_ready`, counter and `rst`. All other outputs are registered.
- The first beat may be accepted in the first cycle after `rst` deasserts.

## Configuration
- `DESERIALIZER_STREAM_LAST_EN` defined:
  - Adds `in_last`, `out_last` and `out_beats`.
  - A beat transferred with `in_last`=1 completes the word immediately, whatever the counter value.
  - Unfilled slices of a short word are zero.
  - `out_last`=1 on that word.
  - `out_beats` = number of valid beats in the word (BEATS for full words).
  - Counter returns to 0.
  - `completing` also includes `in_valid && in_last`.
- Macro undefined: the ports do not exist, every word has exactly BEATS beats, and no flush mechanism exists.

## Structure
- Package `deserializer_stream_pkg`: a function computing `BEATS` and counter width, and an enum `out_state_t` {EMPTY, FULL}.
- Sub-module `deserializer_stream_acc`: accumulator plus beat counter. It outputs `completing` and the assembled word. The top level holds the output register and the handshake.
- Elaboration-time check: stop with an error if `out_width % in_width != 0` or `out_width < 2*in_width`.

## Test plan
- Defaults (1→8, LSB-first): beats 1,0,1,1,0,0,1,0 with `out_ready`=1 → `out_data`=8'h4D one cycle after the 8th beat; `out_valid` high for exactly 1 cycle.
- `in_width`=4, `out_width`=16, `msb_first`=1: nibbles A,B,C,D back-to-back → `out_data`=16'hABCD; a continuous stream yields one word every 4 cycles.
- Backpressure: hold `out_ready`=0 while streaming 16 one-bit beats → the first word is held stable and beats 9–15 are accepted. `in_ready`=0 on beat 16 until `out_ready` rises; the second word then appears the following cycle. No beat lost or duplicated.
- Simultaneous events: `out_ready`=1 in the same cycle as the completing beat of the next word → the new word is loaded, `out_valid` stays 1, and the old word is consumed exactly once.
- Reset mid-word: assert `rst` after 5 beats, then send 8 beats → the first output word contains only the post-reset beats; all outputs are 0 during reset.
- With `DESERIALIZER_STREAM_LAST_EN`, 1→8: beats 1,1,1 with `in_last` on the 3rd → `out_data`=8'h07, `out_last`=1, `out_beats`=3; the next 8 beats form a full word with `out_last`=0 and `out_beats`=8.
